// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the run/pause/clear counter controller.
package count_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV  = 10_000_000;
  localparam int DEF_DB_CYCLES = 1_000_000;

  localparam int NUM_BTN = 2;
  localparam int BTN_RUN = 0;
  localparam int BTN_CLR = 1;
endpackage

// File: rtl/btn_debounce.sv
// Debouncer for one synchronized button; one-cycle press pulse on a debounced rise.
module btn_debounce #(
  parameter int DB_CYCLES = count_ctrl_pkg::DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          level;

  // level flips only after din has disagreed with it for DB_CYCLES straight cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        cnt   <= '0;
        level <= din;
        press <= din;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/count_ctrl.sv
// Run/pause/clear controller for a reversible counter plus LED serializer refresh.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int STOP_AT_LIMIT = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       sw_dir,
  input  logic       rc_in,
  input  logic       p2s_busy,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic       p2s_start,
  output logic [1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [2:0]         sync1, sync2;
  logic [NUM_BTN-1:0] db_press;
  logic               run_p, clr_p, dir_s;
  state_t             state_q, state_d;
  logic [PW-1:0]      presc;
  logic               tick, stop;
  logic               armed, pending;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sw_dir, btn_clr, btn_run};
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rstn  (rstn),
      .din   (sync2[g]),
      .press (db_press[g])
    );
  end

  assign run_p = db_press[BTN_RUN];
  assign clr_p = db_press[BTN_CLR];
  assign dir_s = sync2[2];

  assign tick = (state_q == RUN) && (presc == PMAX);
  // a direction change at the tick moves the counter off the limit, so no stop
  assign stop = (STOP_AT_LIMIT != 0) && rc_in && (dir_s == cnt_dir);

  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (run_p) state_d = RUN;
        RUN:   if (run_p) state_d = PAUSE;
               else if (tick && stop) state_d = DONE;
        PAUSE: if (run_p) state_d = RUN;
        DONE:  state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      presc   <= '0;
      cnt_en  <= 1'b0;
      cnt_dir <= 1'b1;
      cnt_clr <= 1'b0;
    end else begin
      state_q <= state_d;
      // leaving or not yet in RUN parks the prescaler so re-entry gets a full period
      if (state_q != RUN || state_d != RUN || tick) presc <= '0;
      else                                          presc <= presc + 1'b1;
      cnt_en  <= tick && !stop && (state_d == RUN);
      if (tick) cnt_dir <= dir_s;
      cnt_clr <= clr_p;
    end
  end

  // armed keeps p2s_start quiet while reset is held; pending starts set for a post-reset refresh
  assign p2s_start = armed && pending && !p2s_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed   <= 1'b0;
      pending <= 1'b1;
    end else begin
      armed   <= 1'b1;
      pending <= cnt_en || cnt_clr || (pending && !p2s_start);
    end
  end

  assign state = state_q;
endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: stop-at-limit and wrapping instances share stimulus.
module tb_count_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  logic btn_run = 1'b0, btn_clr = 1'b0, sw_dir = 1'b1, rc_in = 1'b0, p2s_busy = 1'b0;
  logic en_s, dir_s, clr_s, p2s_s, en_w, dir_w, clr_w, p2s_w;
  logic [1:0] st_s, st_w;
  int total = 0, bad = 0;
  int n_e, n_w, n_p, n_c;

  typedef struct packed {
    logic       run, clr;
    logic [1:0] st;
    logic       en, cl, p2s;
  } vec_t;
  vec_t tbl [32];

  always #5 clk = ~clk;

  count_ctrl #(.TICK_DIV(4), .DB_CYCLES(2), .STOP_AT_LIMIT(1)) u_s (
    .clk(clk), .rstn(rstn), .btn_run(btn_run), .btn_clr(btn_clr), .sw_dir(sw_dir),
    .rc_in(rc_in), .p2s_busy(p2s_busy), .cnt_en(en_s), .cnt_dir(dir_s),
    .cnt_clr(clr_s), .p2s_start(p2s_s), .state(st_s));

  count_ctrl #(.TICK_DIV(4), .DB_CYCLES(2), .STOP_AT_LIMIT(0)) u_w (
    .clk(clk), .rstn(rstn), .btn_run(btn_run), .btn_clr(btn_clr), .sw_dir(sw_dir),
    .rc_in(rc_in), .p2s_busy(p2s_busy), .cnt_en(en_w), .cnt_dir(dir_w),
    .cnt_clr(clr_w), .p2s_start(p2s_w), .state(st_w));

  task automatic tk();
    @(posedge clk); #3;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_st(input string nm, input logic [1:0] s);
    bit ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      if (st_s == s) ok = 1'b1;
      else tk();
    end
    chk(nm, int'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // run pressed v0..5, run+clr together v19..24
    for (int v = 0; v < 32; v++) begin
      tbl[v].run = (v <= 5) || (v >= 19 && v <= 24);
      tbl[v].clr = (v >= 19 && v <= 24);
      tbl[v].st  = (v >= 5 && v <= 23) ? 2'd1 : 2'd0;
      tbl[v].en  = 1'b0;
      tbl[v].cl  = 1'b0;
      tbl[v].p2s = 1'b0;
    end
    tbl[9].en  = 1'b1; tbl[13].en = 1'b1; tbl[17].en = 1'b1; tbl[21].en = 1'b1;
    tbl[10].p2s = 1'b1; tbl[14].p2s = 1'b1; tbl[18].p2s = 1'b1; tbl[22].p2s = 1'b1;
    tbl[24].cl  = 1'b1; tbl[25].p2s = 1'b1;

    tk(); tk();
    chk("rst_state", int'(st_s), 0);
    chk("rst_en", int'(en_s), 0);
    chk("rst_clr", int'(clr_s), 0);
    chk("rst_p2s", int'(p2s_s), 0);
    chk("rst_dir", int'(dir_s), 1);
    rstn = 1'b1;
    n_p = 0; n_e = 0;
    for (int k = 0; k < 8; k++) begin
      tk(); n_p += int'(p2s_s); n_e += int'(en_s);
    end
    chk("post_rst_p2s", n_p, 1);
    chk("post_rst_en", n_e, 0);
    chk("post_rst_state", int'(st_s), 0);

    for (int v = 0; v < 32; v++) begin
      tk();
      btn_run = tbl[v].run;
      btn_clr = tbl[v].clr;
      #1;
      chk($sformatf("vec%0d", v), int'({st_s, en_s, clr_s, p2s_s}),
          int'({tbl[v].st, tbl[v].en, tbl[v].cl, tbl[v].p2s}));
    end
    btn_run = 1'b0; btn_clr = 1'b0;
    repeat (6) tk();

    // at the limit: stop instance goes DONE, wrap instance keeps counting
    rc_in = 1'b1; btn_run = 1'b1;
    wait_st("wait_run_lim", 2'd1);
    n_e = 0; n_w = 0;
    for (int k = 1; k <= 16; k++) begin
      tk(); if (k == 2) btn_run = 1'b0;
      n_e += int'(en_s); n_w += int'(en_w);
    end
    chk("lim_no_en", n_e, 0);
    chk("lim_state", int'(st_s), 3);
    chk("wrap_en", n_w, 4);
    chk("wrap_state", int'(st_w), 1);

    sw_dir = 1'b0; repeat (6) tk();
    btn_run = 1'b1; repeat (6) tk();
    btn_run = 1'b0; repeat (6) tk();
    chk("done_hold", int'(st_s), 3);

    btn_clr = 1'b1; n_c = 0;
    for (int k = 1; k <= 12; k++) begin
      tk(); if (k == 6) btn_clr = 1'b0;
      n_c += int'(clr_s);
    end
    chk("clr_pulse", n_c, 1);
    chk("clr_state", int'(st_s), 0);
    repeat (4) tk();

    // direction change at first tick escapes the limit once, then stops
    btn_run = 1'b1;
    wait_st("wait_run_dir", 2'd1);
    n_e = 0;
    for (int k = 1; k <= 12; k++) begin
      tk(); if (k == 2) btn_run = 1'b0;
      n_e += int'(en_s);
    end
    chk("dirchg_en", n_e, 1);
    chk("dirchg_state", int'(st_s), 3);
    chk("dirchg_dir", int'(dir_s), 0);

    // refreshes coalesce while the serializer is busy
    btn_clr = 1'b1; p2s_busy = 1'b1; rc_in = 1'b0; sw_dir = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tk(); if (k == 6) btn_clr = 1'b0;
    end
    repeat (4) tk();
    chk("busy_idle", int'(st_s), 0);
    n_p = 0; n_e = 0; btn_run = 1'b1;
    wait_st("wait_run_busy", 2'd1);
    for (int k = 1; k <= 14; k++) begin
      tk(); if (k == 2) btn_run = 1'b0;
      n_e += int'(en_s); n_p += int'(p2s_s);
    end
    chk("busy_en", n_e, 3);
    btn_run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tk(); if (k == 6) btn_run = 1'b0;
      n_p += int'(p2s_s);
    end
    chk("pause_state", int'(st_s), 2);
    repeat (3) begin tk(); n_p += int'(p2s_s); end
    chk("busy_p2s", n_p, 0);
    p2s_busy = 1'b0; #1;
    chk("drop_p2s", int'(p2s_s), 1);
    n_p = 0;
    for (int k = 0; k < 6; k++) begin tk(); n_p += int'(p2s_s); end
    chk("after_drop_p2s", n_p, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clk cycles per count tick (100 ms at 100 MHz); legal range 2 or more.
REQ-002 Parameter DB_CYCLES, default 1_000_000, cycles a synchronized button level must stay stable to count as a press/release.
REQ-003 Parameter STOP_AT_LIMIT, default 1; 1 = halt at terminal count, 0 = let counter wrap.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 btn_run  input  1  raw run/pause pushbutton, active-high, asynchronous to clk.
REQ-007 btn_clr  input  1  raw clear pushbutton, active-high, asynchronous.
REQ-008 sw_dir  input  1  raw direction switch; 1 = up, 0 = down.
REQ-009 rc_in  input  1  counter ripple-carry: high when counter holds terminal value for current direction (16'hFFFF up, 16'h0000 down).
REQ-010 p2s_busy  input  1  LED serializer busy; high while a shift-out is in progress.
REQ-011 cnt_en  output  1  one-cycle count-enable pulse to the reversible counter.
REQ-012 cnt_dir  output  1  registered direction to counter; 1 = up.
REQ-013 cnt_clr  output  1  one-cycle synchronous clear pulse to counter.
REQ-014 p2s_start  output  1  one-cycle start pulse to LED serializer.
REQ-015 state  output  2  current FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3).

Function
REQ-016 btn_run, btn_clr and sw_dir SHALL each pass through a 2-flop synchronizer before any use.
REQ-017 Each button SHALL be debounced: debounced level changes only after the synchronized level is stable for DB_CYCLES consecutive cycles; a 0->1 transition of the debounced level yields exactly one press pulse (run_p / clr_p).
REQ-018 sw_dir SHALL be synchronized but not debounced; cnt_dir SHALL load the synchronized value only in cycles where a tick occurs, so direction never changes between tick and its cnt_en.
REQ-019 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, be held at 0 in all other states, and assert internal tick when it equals TICK_DIV-1, then wrap to 0.
REQ-020 cnt_en SHALL be asserted in the cycle after tick, only if state is still RUN and the stop condition (REQ-024) is false.
REQ-021 FSM transitions: IDLE --run_p--> RUN; RUN --run_p--> PAUSE; PAUSE --run_p--> RUN; DONE --run_p--> no change.
REQ-022 clr_p in any state SHALL force IDLE and assert cnt_clr for exactly one cycle; clr_p has priority over run_p and tick in the same cycle.
REQ-023 Entering RUN from PAUSE SHALL restart the prescaler at 0 (full tick period before the next cnt_en).
REQ-024 With STOP_AT_LIMIT=1, a tick while rc_in=1 and cnt_dir unchanged SHALL suppress cnt_en and move RUN->DONE; with STOP_AT_LIMIT=0, rc_in is ignored and cnt_en issues (counter wraps).
REQ-025 A direction change at a tick clears the stop condition for that tick (counter moves away from limit).
REQ-026 An internal refresh_pending flag SHALL set in the cycle after any cnt_en or cnt_clr pulse.
REQ-027 p2s_start SHALL pulse for one cycle when refresh_pending=1 and p2s_busy=0, clearing refresh_pending in the same cycle; further updates while busy coalesce into one pending refresh.
REQ-028 Set and issue of refresh_pending in the same cycle: set wins, pending remains 1.

Reset
REQ-029 rstn low SHALL immediately force: state=IDLE, prescaler=0, debouncers to released, synchronizers to 0, cnt_dir=1, cnt_en=0, cnt_clr=0, p2s_start=0, refresh_pending=1 (display refresh after reset).
REQ-030 Reset release mid-press SHALL NOT produce a press pulse until a full debounced 0->1 transition is observed.

Structure
REQ-031 FSM state encoding constants and the default TICK_DIV/DB_CYCLES values SHALL live in a shared package used by the top level.
REQ-032 Debounce+edge logic SHALL be a sub-module btn_debounce, instantiated twice.

Verification (TICK_DIV=4, DB_CYCLES=2, STOP_AT_LIMIT=1 unless noted)
REQ-033 Reset release, no input -> state=0, one p2s_start once p2s_busy=0, no cnt_en.
REQ-034 Press btn_run -> state=1 within sync+debounce latency; cnt_en pulses exactly every 4 cycles; each followed by p2s_start when p2s_busy=0.
REQ-035 In RUN, btn_run and btn_clr debounced in the same cycle -> state=0, one cnt_clr pulse, no cnt_en afterwards.
REQ-036 RUN, sw_dir=1, rc_in=1 at tick -> no cnt_en, state=3; then sw_dir=0 and press run -> state stays 3; press clr -> state=0.
REQ-037 STOP_AT_LIMIT=0, rc_in=1 held -> cnt_en continues every 4 cycles, state stays 1.
REQ-038 p2s_busy held high across 3 cnt_en pulses -> zero p2s_start while busy, exactly one p2s_start on the cycle busy drops.
